ast_pack: RTL and testbench
===========================

AST_PACK -- requirements
Module: ast_pack

Interface
REQ-001 Parameters SHALL be: BYTE_W, 8, symbol width in bits; AST_SOURCE_SYMBOLS (S), 8, symbols per beat; AST_SOURCE_ORDER, 1'b1, 1 = first byte of a beat on the MSB symbol; AST_SOURCE_EMPTY_W, S==1 ? 1 : $clog2(S), empty width; IN_CNT_W, $clog2(S)+1, byte-count width.
REQ-002 Ports SHALL be: clk_i in 1 clock; srst_i in 1 reset; the block uses one clock, and reset is synchronous and active-high.
REQ-003 in_data_i in S*BYTE_W input bytes, with in_data_i[0] the oldest byte.
REQ-004 in_cnt_i in IN_CNT_W count of valid bytes, held contiguous from index 0.
REQ-005 in_last_i in 1 marks the final input word of a packet; in_valid_i in 1; in_ready_o out 1.
REQ-006 ast_source_data_o out S*BYTE_W; ast_source_valid_o out 1; ast_source_ready_i in 1.
REQ-007 ast_source_startofpacket_o out 1; ast_source_endofpacket_o out 1; ast_source_empty_o out AST_SOURCE_EMPTY_W.

Function
REQ-008 The block SHALL hold an accumulation buffer of 2*S bytes and a fill counter of width $clog2(2*S)+1, with the oldest byte at index 0.
REQ-009 An input transfer SHALL be in_valid_i && in_ready_o, and an output transfer SHALL be ast_source_valid_o && ast_source_ready_i.
REQ-010 The FSM SHALL have two states: FILL_S (accepting input) and FLUSH_S (draining the tail of a packet).
REQ-011 In FILL_S, in_ready_o = (fill <= S) || output transfer; in FLUSH_S, in_ready_o = 0.
REQ-012 On an input transfer, min(in_cnt_i, S) bytes SHALL be appended at position fill (after any same-cycle pop); in_cnt_i > S is clamped to S; in_cnt_i = 0 without last is accepted with no effect.
REQ-013 On an output transfer, S bytes (or all remaining bytes, if fewer) SHALL be removed from the buffer head, and the remaining bytes shift down.
REQ-014 ast_source_valid_o SHALL be (fill >= S) in FILL_S and (fill > 0) in FLUSH_S; outputs are driven from registers only, so the minimum input-to-output latency is 1 cycle.
REQ-015 An input transfer with in_last_i=1 SHALL move the FSM FILL_S -> FLUSH_S.
REQ-016 In FLUSH_S, the FSM SHALL return to FILL_S on the output transfer that carries eop, or in the next cycle if fill == 0.
REQ-017 In FLUSH_S, a beat with fill > S SHALL be a full beat with eop=0.
REQ-018 In FLUSH_S, the beat with fill <= S SHALL have eop=1 and empty = S - fill, and its unused symbols SHALL be driven to zero.
REQ-019 The empty output SHALL be 0 on every non-eop beat.
REQ-020 A sop_pending flag SHALL be set at reset and after an eop transfer, and cleared on any output transfer.
REQ-021 startofpacket = valid && sop_pending, so a one-beat packet carries sop=1 and eop=1 together.
REQ-022 A zero-length packet (last accepted with the resulting fill == 0) SHALL produce no beat, return the FSM to FILL_S, and leave sop_pending set.
REQ-023 While valid && !ready, the data, sop, eop and empty outputs SHALL remain stable; bytes appended at or beyond index S SHALL NOT alter the presented beat.
REQ-024 With AST_SOURCE_ORDER=1, output symbol j SHALL be ast_source_data_o[S-1-j]; with AST_SOURCE_ORDER=0, it SHALL be ast_source_data_o[j].
REQ-025 Simultaneous push and pop SHALL compute fill' = fill - popped + pushed in a single cycle, with no byte lost or duplicated.
REQ-026 The fill counter SHALL never exceed 2*S; an overflow is a design error, and the bench SHALL assert on it.

Reset
REQ-027 While srst_i=1, on the next clock edge: state = FILL_S, fill = 0, sop_pending = 1, valid = 0, eop = 0, empty = 0, and buffer contents are don't-care.
REQ-028 A reset asserted mid-packet SHALL discard all buffered bytes, and the first beat after reset SHALL carry sop=1.
REQ-029 in_ready_o SHALL be 1 in the first cycle after reset is released.

Verification (S=8, BYTE_W=8, ready=1 unless stated)
REQ-030 Inputs cnt 8, 8, 4 with last on the third -> 3 beats; beat 1 sop=1; beat 3 eop=1, empty=4; byte order preserved.
REQ-031 Inputs cnt 3, 3, 3 with last on the third (9 bytes) -> 2 beats; beat 2 eop=1, empty=7; the first byte of the packet appears on data_o[63:56].
REQ-032 A single input cnt 5 with last -> 1 beat with sop=1, eop=1, empty=3, and data_o[23:0]=0.
REQ-033 fill = 16 with ready held at 0 for 4 cycles -> in_ready_o = 0 and the output beat is stable throughout; after ready rises, all 16 bytes emerge in order.
REQ-034 in_last with cnt 0 on an empty buffer -> no beat; the first beat of the next packet carries sop=1.
REQ-035 srst_i pulsed after 12 bytes of a packet -> valid = 0 on the next cycle; the next packet's first beat carries sop=1 and contains no stale bytes.

Source files
------------

// File: rtl/ast_pack_if.sv
// Handshake bundle for ast_pack: byte-count input stream in, Avalon-ST packet stream out.
interface ast_pack_if #(
    parameter int BYTE_W  = 8,
    parameter int S       = 8,
    parameter int EMPTY_W = (S == 1) ? 1 : $clog2(S),
    parameter int CNT_W   = $clog2(S) + 1
) ();
    logic [S*BYTE_W-1:0]  in_data_i;
    logic [CNT_W-1:0]     in_cnt_i;
    logic                 in_last_i;
    logic                 in_valid_i;
    logic                 in_ready_o;

    logic [S*BYTE_W-1:0]  ast_source_data_o;
    logic                 ast_source_valid_o;
    logic                 ast_source_ready_i;
    logic                 ast_source_startofpacket_o;
    logic                 ast_source_endofpacket_o;
    logic [EMPTY_W-1:0]   ast_source_empty_o;

    modport slave (
        input  in_data_i, in_cnt_i, in_last_i, in_valid_i,
        output in_ready_o,
        output ast_source_data_o, ast_source_valid_o,
        output ast_source_startofpacket_o, ast_source_endofpacket_o, ast_source_empty_o,
        input  ast_source_ready_i
    );

    modport master (
        output in_data_i, in_cnt_i, in_last_i, in_valid_i,
        input  in_ready_o,
        input  ast_source_data_o, ast_source_valid_o,
        input  ast_source_startofpacket_o, ast_source_endofpacket_o, ast_source_empty_o,
        output ast_source_ready_i
    );
endinterface

// File: rtl/ast_pack.sv
// Packs variable-count byte words into full S-symbol Avalon-ST beats with sop/eop/empty framing.
module ast_pack #(
    parameter int BYTE_W             = 8,
    parameter int AST_SOURCE_SYMBOLS = 8,
    parameter bit AST_SOURCE_ORDER   = 1'b1,
    parameter int AST_SOURCE_EMPTY_W = (AST_SOURCE_SYMBOLS == 1) ? 1 : $clog2(AST_SOURCE_SYMBOLS),
    parameter int IN_CNT_W           = $clog2(AST_SOURCE_SYMBOLS) + 1
) (
    input  logic       clk_i,
    input  logic       srst_i,
    ast_pack_if.slave  bus
);
    localparam int S      = AST_SOURCE_SYMBOLS;
    localparam int FILL_W = $clog2(2 * S) + 1;
    localparam int IDX_W  = (S == 1) ? 1 : $clog2(S);
    localparam logic [FILL_W-1:0] S_F = FILL_W'(S);

    typedef enum logic {FILL_S, FLUSH_S} state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                sop_pend_q, sop_pend_d;
    logic [BYTE_W-1:0]   buf_q [2*S];
    logic [BYTE_W-1:0]   buf_d [2*S];
    logic [BYTE_W-1:0]   in_bytes [S];

    logic                src_valid, src_eop, out_xfer, in_ready, in_xfer;
    logic [FILL_W-1:0]   push_n, pop_n, base;
    logic [S*BYTE_W-1:0] out_data;

    // Presented beat is decoded purely from registered state, so inputs never reach outputs combinationally.
    always_comb begin
        src_valid = (state_q == FILL_S) ? (fill_q >= S_F) : (fill_q != '0);
        src_eop   = (state_q == FLUSH_S) && (fill_q != '0) && (fill_q <= S_F);
        out_xfer  = src_valid && bus.ast_source_ready_i;
        in_ready  = (state_q == FILL_S) && ((fill_q <= S_F) || out_xfer);
        in_xfer   = bus.in_valid_i && in_ready;
        push_n    = (bus.in_cnt_i > IN_CNT_W'(S)) ? S_F : FILL_W'(bus.in_cnt_i);
        pop_n     = '0;
        if (out_xfer) begin
            pop_n = src_eop ? fill_q : S_F;
        end
        base      = fill_q - pop_n;
        fill_d    = base + (in_xfer ? push_n : '0);
    end

    always_comb begin
        state_d    = state_q;
        sop_pend_d = sop_pend_q;
        if (out_xfer) begin
            sop_pend_d = src_eop;
        end
        case (state_q)
            FILL_S: begin
                if (in_xfer && bus.in_last_i) begin
                    state_d = FLUSH_S;
                end
            end
            FLUSH_S: begin
                if ((out_xfer && src_eop) || (fill_q == '0)) begin
                    state_d = FILL_S;
                end
            end
            default: state_d = FILL_S;
        endcase
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_in
        assign in_bytes[gi] = bus.in_data_i[gi*BYTE_W +: BYTE_W];
    end

    // Pops are always S bytes (an eop pop empties the buffer, so its leftover contents are don't-care).
    for (genvar gi = 0; gi < 2 * S; gi++) begin : g_buf
        logic [FILL_W-1:0] off;
        logic [IDX_W-1:0]  off_idx;
        logic [BYTE_W-1:0] shifted;
        logic              hit;
        assign off     = FILL_W'(gi) - base;
        assign off_idx = off[IDX_W-1:0];
        if (gi + S < 2 * S) begin : g_sh
            assign shifted = out_xfer ? buf_q[gi+S] : buf_q[gi];
        end else begin : g_top
            assign shifted = out_xfer ? '0 : buf_q[gi];
        end
        assign hit        = in_xfer && (FILL_W'(gi) >= base) && (off < push_n);
        assign buf_d[gi]  = hit ? in_bytes[off_idx] : shifted;
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_out
        localparam int SLOT = AST_SOURCE_ORDER ? (S - 1 - gi) : gi;
        assign out_data[SLOT*BYTE_W +: BYTE_W] =
            (src_eop && (FILL_W'(gi) >= fill_q)) ? '0 : buf_q[gi];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= FILL_S;
            fill_q     <= '0;
            sop_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            sop_pend_q <= sop_pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2 * S; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

    assign bus.in_ready_o                 = in_ready;
    assign bus.ast_source_valid_o         = src_valid;
    assign bus.ast_source_data_o          = out_data;
    assign bus.ast_source_startofpacket_o = src_valid && sop_pend_q;
    assign bus.ast_source_endofpacket_o   = src_eop;
    assign bus.ast_source_empty_o         = src_eop ? AST_SOURCE_EMPTY_W'(S_F - fill_q) : '0;
endmodule

// File: tb/tb_ast_pack.sv
// Randomized bench for ast_pack: packets are chunked into expected beats by a byte-queue model.
module tb_ast_pack;
    localparam int S  = 8;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic srst = 1'b1;
    int   ready_mode = 1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ast_pack_if #(.BYTE_W(BW), .S(S)) bus ();

    ast_pack #(.BYTE_W(BW), .AST_SOURCE_SYMBOLS(S), .AST_SOURCE_ORDER(1'b1)) u_dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [S*BW-1:0] data;
        logic            sop;
        logic            eop;
        logic [2:0]      empty;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] cur_q[$];
    bit         pkt_first = 1'b1;

    bit              hold_v = 1'b0;
    logic [S*BW-1:0] hold_data;
    logic            hold_sop, hold_eop;
    logic [2:0]      hold_empty;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One beat of n bytes from the head of the current packet, first byte on the top symbol.
    function automatic void emit(input int n, input bit eop);
        beat_t b;
        b.data = '0;
        for (int j = 0; j < n; j++) begin
            b.data[(S-1-j)*BW +: BW] = cur_q.pop_front();
        end
        b.sop   = pkt_first;
        b.eop   = eop;
        b.empty = eop ? 3'(S - n) : 3'd0;
        pkt_first = eop;
        exp_q.push_back(b);
    endfunction

    function automatic void model_accept(input logic [S*BW-1:0] d, input int cnt, input bit last);
        int n;
        n = (cnt > S) ? S : cnt;
        for (int i = 0; i < n; i++) begin
            cur_q.push_back(d[i*BW +: BW]);
        end
        if (!last) begin
            while (cur_q.size() >= S) emit(S, 1'b0);
        end else begin
            while (cur_q.size() > S) emit(S, 1'b0);
            if (cur_q.size() > 0) emit(cur_q.size(), 1'b1);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        cur_q.delete();
        pkt_first = 1'b1;
    endfunction

    initial begin
        bus.ast_source_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.ast_source_ready_i = ($urandom_range(0, 3) != 0);
                1:       bus.ast_source_ready_i = 1'b1;
                default: bus.ast_source_ready_i = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (srst) begin
            hold_v = 1'b0;
        end else begin
            check_val("fill_bound", 64'(u_dut.fill_q <= 5'd16), 64'd1);
            if (hold_v) begin
                check_val("stable_valid", 64'(bus.ast_source_valid_o), 64'd1);
                check_val("stable_data", bus.ast_source_data_o, hold_data);
                check_val("stable_sop", 64'(bus.ast_source_startofpacket_o), 64'(hold_sop));
                check_val("stable_eop", 64'(bus.ast_source_endofpacket_o), 64'(hold_eop));
                check_val("stable_empty", 64'(bus.ast_source_empty_o), 64'(hold_empty));
            end
            if (bus.ast_source_valid_o && bus.ast_source_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", bus.ast_source_data_o, 64'hx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_val("beat_data", bus.ast_source_data_o, e.data);
                    check_val("beat_sop", 64'(bus.ast_source_startofpacket_o), 64'(e.sop));
                    check_val("beat_eop", 64'(bus.ast_source_endofpacket_o), 64'(e.eop));
                    check_val("beat_empty", 64'(bus.ast_source_empty_o), 64'(e.empty));
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                model_accept(bus.in_data_i, int'(bus.in_cnt_i), bus.in_last_i);
            end
            hold_v     = bus.ast_source_valid_o && !bus.ast_source_ready_i;
            hold_data  = bus.ast_source_data_o;
            hold_sop   = bus.ast_source_startofpacket_o;
            hold_eop   = bus.ast_source_endofpacket_o;
            hold_empty = bus.ast_source_empty_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int cnt, input bit last);
        int t = 0;
        bus.in_data_i  = {$urandom, $urandom};
        bus.in_cnt_i   = 4'(cnt);
        bus.in_last_i  = last;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_val(tag, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check_val({tag, "_idle"}, 64'(bus.ast_source_valid_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.in_data_i  = '0;
        bus.in_cnt_i   = '0;
        bus.in_last_i  = 1'b0;
        bus.in_valid_i = 1'b0;
        idle(3);
        srst = 1'b0;
        @(negedge clk);
        check_val("rst_valid", 64'(bus.ast_source_valid_o), 64'd0);
        check_val("rst_sop", 64'(bus.ast_source_startofpacket_o), 64'd0);
        check_val("rst_eop", 64'(bus.ast_source_endofpacket_o), 64'd0);
        check_val("rst_empty", 64'(bus.ast_source_empty_o), 64'd0);
        check_val("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Three-beat packet ending with a half beat.
        send(8, 0); send(8, 0); send(4, 1);
        drain("pkt_8_8_4");
        // Small words straddling a beat boundary.
        send(3, 0); send(3, 0); send(3, 1);
        drain("pkt_3_3_3");
        // One-beat packet: sop and eop together, low symbols zeroed.
        send(5, 1);
        drain("pkt_5");

        // Full buffer under backpressure.
        ready_mode = 2;
        idle(1);
        send(8, 0); send(8, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            check_val("bp_valid", 64'(bus.ast_source_valid_o), 64'd1);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(4, 1);
        drain("pkt_backpressure");

        // Zero-length packet, then a normal one that must still carry sop.
        send(0, 1);
        idle(2);
        send(8, 1);
        drain("pkt_zero_len");

        // Reset in the middle of a packet.
        ready_mode = 2;
        idle(1);
        send(8, 0); send(4, 0);
        pulse_reset();
        @(negedge clk);
        check_val("mid_rst_valid", 64'(bus.ast_source_valid_o), 64'd0);
        check_val("mid_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(8, 1);
        drain("pkt_after_rst");

        // Random packets, random backpressure, counts including clamped ones.
        ready_mode = 0;
        for (int p = 0; p < 40; p++) begin
            int words;
            words = $urandom_range(1, 5);
            for (int w = 0; w < words - 1; w++) begin
                send($urandom_range(0, 11), 0);
                idle($urandom_range(0, 2));
            end
            send($urandom_range(1, 11), 1);
            idle($urandom_range(0, 2));
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
